// File: rtl/sprite_game_draw_engine_if.sv
// Host, sprite-ROM and frame-buffer signals of the sprite draw engine.
// The sprite type field is named sprite_type because "type" is a reserved word.
`default_nettype none

interface sprite_game_draw_engine_if;
    logic        sprite;
    logic        start;
    logic [1:0]  sprite_type;
    logic [5:0]  X;
    logic [5:0]  Y;
    logic [11:0] bg_color;
    logic [1:0]  game_mode;
    logic        ready;
    logic        done;
    logic        SR0_CEN;
    logic [8:0]  SR0_A;
    logic [12:0] SR0_Q;
    logic        SR1_CEN;
    logic [8:0]  SR1_A;
    logic [12:0] SR1_Q;
    logic        FB_CEN;
    logic        FB_WEN;
    logic [11:0] FB_A;
    logic [11:0] FB_D;
    logic [11:0] FB_Q;

    modport slave (
        input  sprite, start, sprite_type, X, Y, bg_color, game_mode,
        input  SR0_Q, SR1_Q, FB_Q,
        output ready, done, SR0_CEN, SR0_A, SR1_CEN, SR1_A,
        output FB_CEN, FB_WEN, FB_A, FB_D
    );

    modport master (
        output sprite, start, sprite_type, X, Y, bg_color, game_mode,
        output SR0_Q, SR1_Q, FB_Q,
        input  ready, done, SR0_CEN, SR0_A, SR1_CEN, SR1_A,
        input  FB_CEN, FB_WEN, FB_A, FB_D
    );
endinterface

`default_nettype wire

// File: rtl/sprite_game_draw_engine.sv
// Sprite draw engine: clears a 64x64 frame buffer, collects up to N_SPRITE_MAX
// sprite entries, then renders them from two sprite ROMs with clipping and mirroring.
`default_nettype none

module sprite_game_draw_engine #(
    parameter int N_SPRITE_MAX = 20,
    parameter int FB_DIM       = 64,
    parameter int SPR_DIM      = 16
) (
    input  wire logic                  clk,
    input  wire logic                  reset,
    sprite_game_draw_engine_if.slave   bus
);
    localparam int          CW         = $clog2(N_SPRITE_MAX + 1);
    localparam logic [11:0] CLEAR_LAST = 12'(FB_DIM * FB_DIM - 1);
    localparam logic [7:0]  PIX_LAST   = 8'(SPR_DIM * SPR_DIM - 1);

    typedef enum logic [1:0] {CLEAR = 2'd0, LOAD = 2'd1, DRAW = 2'd2, DONE = 2'd3} state_t;

    state_t        state;
    logic [5:0]    spr_x [N_SPRITE_MAX];
    logic [5:0]    spr_y [N_SPRITE_MAX];
    logic [1:0]    spr_t [N_SPRITE_MAX];
    logic [CW-1:0] count;
    logic [CW-1:0] idx;
    logic [11:0]   clr_addr;
    logic [7:0]    pix;
    logic          issuing;
    // Stage 1: ROM address presented; stage 2: ROM data valid.
    logic          v1, v2, sel1, sel2, in1, in2;
    logic [11:0]   fa1, fa2;

    logic          load_take;
    logic [5:0]    cx, cy;
    logic [1:0]    ct;
    logic [3:0]    r, c, rr, cc;
    logic [6:0]    dx, dy;
    logic [12:0]   q;
    logic          unused_fb_q;

    assign unused_fb_q = ^bus.FB_Q;
    assign load_take   = (state == LOAD) && bus.sprite && !bus.start
                         && (count < CW'(N_SPRITE_MAX));
    assign q           = sel2 ? bus.SR1_Q : bus.SR0_Q;

    always_comb begin
        cx = spr_x[idx];
        cy = spr_y[idx];
        ct = spr_t[idx];
        r  = pix[7:4];
        c  = pix[3:0];
        rr = bus.game_mode[1] ? (4'd15 - r) : r;
        cc = bus.game_mode[0] ? (4'd15 - c) : c;
        // 7-bit sums so anything past the right/bottom edge clips instead of wrapping.
        dx = {1'b0, cx} + {3'b000, c};
        dy = {1'b0, cy} + {3'b000, r};
    end

    always_ff @(posedge clk) begin
        if (load_take) begin
            spr_x[count] <= bus.X;
            spr_y[count] <= bus.Y;
            spr_t[count] <= bus.sprite_type;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state       <= CLEAR;
            count       <= '0;
            idx         <= '0;
            clr_addr    <= '0;
            pix         <= '0;
            issuing     <= 1'b0;
            v1          <= 1'b0;
            v2          <= 1'b0;
            sel1        <= 1'b0;
            sel2        <= 1'b0;
            in1         <= 1'b0;
            in2         <= 1'b0;
            fa1         <= '0;
            fa2         <= '0;
            bus.ready   <= 1'b0;
            bus.done    <= 1'b0;
            bus.SR0_CEN <= 1'b1;
            bus.SR1_CEN <= 1'b1;
            bus.SR0_A   <= '0;
            bus.SR1_A   <= '0;
            bus.FB_CEN  <= 1'b1;
            bus.FB_WEN  <= 1'b1;
            bus.FB_A    <= '0;
            bus.FB_D    <= '0;
        end else begin
            bus.SR0_CEN <= 1'b1;
            bus.SR1_CEN <= 1'b1;
            bus.FB_CEN  <= 1'b1;
            bus.FB_WEN  <= 1'b1;
            v1          <= 1'b0;
            v2          <= v1;
            sel2        <= sel1;
            in2         <= in1;
            fa2         <= fa1;
            case (state)
                CLEAR: begin
                    bus.FB_CEN <= 1'b0;
                    bus.FB_WEN <= 1'b0;
                    bus.FB_A   <= clr_addr;
                    bus.FB_D   <= bus.bg_color;
                    clr_addr   <= clr_addr + 12'd1;
                    if (clr_addr == CLEAR_LAST) begin
                        state     <= LOAD;
                        bus.ready <= 1'b1;
                    end
                end
                LOAD: begin
                    if (bus.start) begin
                        bus.ready <= 1'b0;
                        idx       <= '0;
                        pix       <= '0;
                        if (count == '0) begin
                            state    <= DONE;
                            bus.done <= 1'b1;
                        end else begin
                            state   <= DRAW;
                            issuing <= 1'b1;
                        end
                    end else if (load_take) begin
                        count <= count + CW'(1);
                    end
                end
                DRAW: begin
                    if (issuing) begin
                        bus.SR0_CEN <= ct[1];
                        bus.SR1_CEN <= !ct[1];
                        bus.SR0_A   <= {ct[0], rr, cc};
                        bus.SR1_A   <= {ct[0], rr, cc};
                        v1          <= 1'b1;
                        sel1        <= ct[1];
                        in1         <= !dx[6] && !dy[6];
                        fa1         <= {dy[5:0], dx[5:0]};
                        pix         <= pix + 8'd1;
                        if (pix == PIX_LAST) begin
                            if (idx == count - CW'(1)) issuing <= 1'b0;
                            else                       idx     <= idx + CW'(1);
                        end
                    end else if (!v1 && !v2) begin
                        state    <= DONE;
                        bus.done <= 1'b1;
                    end
                    if (v2) begin
                        bus.FB_CEN <= q[12] || !in2;
                        bus.FB_WEN <= q[12] || !in2;
                        bus.FB_A   <= fa2;
                        bus.FB_D   <= q[11:0];
                    end
                end
                default: begin
                    bus.done <= 1'b1;
                end
            endcase
        end
    end
endmodule

`default_nettype wire

// File: tb/tb_sprite_game_draw_engine.sv
// Self-checking bench: behavioural ROM/FB models and a frame-level reference renderer.
`default_nettype none

module tb_sprite_game_draw_engine;
    logic clk = 1'b0;
    logic reset = 1'b1;
    always #5 clk = ~clk;

    sprite_game_draw_engine_if bus ();

    sprite_game_draw_engine dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    logic [12:0] rom0 [512];
    logic [12:0] rom1 [512];
    logic [11:0] fb     [4096];
    logic [11:0] fb_exp [4096];

    int ld_x [32];
    int ld_y [32];
    int ld_t [32];
    int combo_x, combo_y, combo_t;
    logic [11:0] bg;

    int errors = 0;
    int checks = 0;

    always @(posedge clk) begin
        if (!bus.SR0_CEN) bus.SR0_Q <= rom0[bus.SR0_A];
        if (!bus.SR1_CEN) bus.SR1_Q <= rom1[bus.SR1_A];
        if (!bus.FB_CEN) begin
            if (!bus.FB_WEN) fb[bus.FB_A] <= bus.FB_D;
            else             bus.FB_Q     <= fb[bus.FB_A];
        end
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Reference renderer: paint every stored sprite straight from the ROM arrays.
    task automatic build_model(input int n, input int mode);
        int nd;
        for (int a = 0; a < 4096; a++) fb_exp[a] = bg;
        nd = (n > 20) ? 20 : n;
        for (int s = 0; s < nd; s++) begin
            for (int r = 0; r < 16; r++) begin
                for (int c = 0; c < 16; c++) begin
                    int rr, cc, addr, x, y;
                    logic [12:0] w;
                    rr   = (mode & 2) ? 15 - r : r;
                    cc   = (mode & 1) ? 15 - c : c;
                    addr = (ld_t[s] % 2) * 256 + rr * 16 + cc;
                    w    = (ld_t[s] >= 2) ? rom1[addr] : rom0[addr];
                    x    = ld_x[s] + c;
                    y    = ld_y[s] + r;
                    if (!w[12] && x < 64 && y < 64) fb_exp[y * 64 + x] = w[11:0];
                end
            end
        end
    endtask

    task automatic run(input string name, input int n, input int mode,
                       input bit combo, input bit midreset);
        int cyc, bad, first, nd;
        bus.bg_color  = bg;
        bus.game_mode = 2'(mode);
        @(negedge clk);
        reset = 1'b1; bus.sprite = 1'b0; bus.start = 1'b0;
        repeat (3) @(negedge clk);
        check({name, ":reset_ctl"},
              {26'd0, bus.ready, bus.done, bus.FB_CEN, bus.FB_WEN, bus.SR0_CEN, bus.SR1_CEN},
              32'b001111);
        check({name, ":reset_addr"}, (bus.FB_A | bus.FB_D | 12'(bus.SR0_A) | 12'(bus.SR1_A)), 0);
        reset = 1'b0;
        if (midreset) begin
            repeat (200) @(negedge clk);
            reset = 1'b1;
            repeat (2) @(negedge clk);
            reset = 1'b0;
        end
        cyc = 0;
        while (!bus.ready && cyc < 6000) begin @(negedge clk); cyc++; end
        check({name, ":ready_cycles"}, cyc, 4096);

        for (int i = 0; i < n; i++) begin
            bus.sprite = 1'b1;
            bus.X = 6'(ld_x[i]); bus.Y = 6'(ld_y[i]); bus.sprite_type = 2'(ld_t[i]);
            @(negedge clk);
        end
        bus.sprite = combo;
        bus.X = 6'(combo_x); bus.Y = 6'(combo_y); bus.sprite_type = 2'(combo_t);
        bus.start = 1'b1;
        @(negedge clk);
        bus.sprite = 1'b0; bus.start = 1'b0;
        check({name, ":ready_drop"}, bus.ready, 0);

        nd  = (n > 20) ? 20 : n;
        cyc = 1;
        while (!bus.done && cyc < 256 * nd + 100) begin @(negedge clk); cyc++; end
        check({name, ":done"}, bus.done, 1);
        check({name, ":draw_cycles"}, (cyc >= 256 * nd + 1 && cyc <= 256 * nd + 5), 1);

        bus.start = 1'b1; bus.sprite = 1'b1;
        repeat (3) @(negedge clk);
        bus.start = 1'b0; bus.sprite = 1'b0;
        check({name, ":done_hold"},
              {28'd0, bus.done, bus.FB_CEN, bus.SR0_CEN, bus.SR1_CEN}, 32'hF);

        build_model(n, mode);
        bad = 0; first = -1;
        for (int a = 0; a < 4096; a++) begin
            if (fb[a] !== fb_exp[a]) begin
                bad++;
                if (first < 0) first = a;
            end
        end
        check($sformatf("%s:frame_bad_pixels(first=%0d)", name, first), bad, 0);
    endtask

    initial begin
        bus.sprite = 0; bus.start = 0; bus.sprite_type = 0; bus.X = 0; bus.Y = 0;
        bus.bg_color = 0; bus.game_mode = 0; bus.FB_Q = 0; bus.SR0_Q = 0; bus.SR1_Q = 0;
        combo_x = 0; combo_y = 0; combo_t = 0;
        // Types 1 and 2 are fully opaque; types 0 and 3 have ~25% transparent pixels.
        for (int i = 0; i < 512; i++) begin
            rom0[i] = {($urandom_range(0, 3) == 0), 12'($urandom)};
            rom1[i] = {($urandom_range(0, 3) == 0), 12'($urandom)};
            if (i >= 256) rom0[i][12] = 1'b0;
            if (i < 256)  rom1[i][12] = 1'b0;
        end
        rom0[0] = 13'h0ABC;
        rom0[1] = 13'h1123;

        bg = 12'hB97;
        run("empty", 0, 0, 0, 0);

        ld_x[0] = 0; ld_y[0] = 0; ld_t[0] = 0;
        run("origin", 1, 0, 0, 0);
        check("origin:fb0", fb[0], 12'hABC);
        check("origin:fb1_transparent", fb[1], 12'hB97);

        bg = 12'(($urandom));
        ld_x[0] = 60; ld_y[0] = 60; ld_t[0] = 3;
        run("corner", 1, 0, 0, 0);
        check("corner:fb0_nowrap", fb[0], bg);
        check("corner:fb63_nowrap", fb[63], bg);

        ld_x[0] = 10; ld_y[0] = 10; ld_t[0] = 1;
        ld_x[1] = 14; ld_y[1] = 10; ld_t[1] = 2;
        run("overlap", 2, 0, 0, 0);
        check("overlap:second_wins", fb[10 * 64 + 14], rom1[0][11:0]);
        check("overlap:first_left", fb[10 * 64 + 10], rom0[256][11:0]);

        ld_x[0] = 5; ld_y[0] = 7; ld_t[0] = 1;
        run("hmirror", 1, 1, 0, 0);
        check("hmirror:topleft", fb[7 * 64 + 5], rom0[256 + 15][11:0]);
        run("bothmirror", 1, 3, 0, 0);
        check("bothmirror:topleft", fb[7 * 64 + 5], rom0[511][11:0]);

        bg = 12'(($urandom));
        for (int i = 0; i < 20; i++) begin
            ld_x[i] = $urandom_range(0, 63);
            ld_y[i] = $urandom_range(20, 63);
            ld_t[i] = $urandom_range(0, 3);
        end
        ld_x[20] = 0; ld_y[20] = 0; ld_t[20] = 1;
        combo_x = 16; combo_y = 0; combo_t = 2;
        run("overflow", 21, $urandom_range(0, 3), 1, 1);
        check("overflow:entry21_dropped", fb[0], bg);
        check("overflow:combo_dropped", fb[16], bg);

        bg = 12'(($urandom));
        for (int i = 0; i < 5; i++) begin
            ld_x[i] = $urandom_range(0, 63);
            ld_y[i] = $urandom_range(0, 63);
            ld_t[i] = $urandom_range(0, 3);
        end
        run("random", $urandom_range(1, 5), $urandom_range(0, 3), 0, 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule

`default_nettype wire

// File: doc/sprite_game_draw_engine.md
Name:
sprite_game_draw_engine

Overview:
- Sprite graphics drawing engine. Renders a list of up to 20 sprites into a 64x64, 12-bit-colour frame buffer.
- Sprite bitmaps come from two external synchronous sprite ROMs (SR0, SR1). Output goes to an external synchronous single-port frame-buffer SRAM (FB).
- Flow: host loads sprite entries while `ready` is high, pulses `start`, waits for `done`, then reads the FB directly.

Parameters:
- N_SPRITE_MAX, 20, maximum number of stored sprite entries.
- FB_DIM, 64, frame width and height in pixels (FB address = y*64 + x).
- SPR_DIM, 16, sprite width and height in pixels.

Ports:
- clk  in  1  single clock; all logic on rising edge.
- reset  in  1  synchronous, active-high reset.
- sprite  in  1  load strobe; one entry captured per cycle while high and `ready`=1.
- start  in  1  one-cycle pulse: begin rendering.
- type  in  2  sprite type of the entry being loaded.
- X  in  6  sprite top-left x.
- Y  in  6  sprite top-left y.
- bg_color  in  12  background colour (static).
- game_mode  in  2  mirror mode (static).
- ready  out  1  engine accepting sprite entries.
- done  out  1  rendering complete.
- SR0_CEN  out  1  SR0 chip enable, active low.
- SR0_A  out  9  SR0 address.
- SR0_Q  in  13  SR0 read data.
- SR1_CEN  out  1  SR1 chip enable, active low.
- SR1_A  out  9  SR1 address.
- SR1_Q  in  13  SR1 read data.
- FB_CEN  out  1  FB chip enable, active low.
- FB_WEN  out  1  FB write enable, active low.
- FB_A  out  12  FB address.
- FB_D  out  12  FB write data.
- FB_Q  in  12  FB read data (unused by the engine).

Behaviour:
- Memories:
  - SR and FB are synchronous: address and enables sampled at the rising edge; Q is valid after that edge (1-cycle read latency).
  - FB write happens at the edge when CEN=0 and WEN=0.
- Reset values: `ready`=0, `done`=0, all CEN=1, `FB_WEN`=1, all addresses and `FB_D`=0, sprite count=0, state=CLEAR.
- Reset at any time aborts the current operation and returns to CLEAR.
- State CLEAR:
  - Write `bg_color` to FB addresses 0..4095, one per cycle, ascending.
  - After address 4095 go to LOAD.
- State LOAD:
  - `ready`=1.
  - Each rising edge with `sprite`=1 appends {X,Y,type} at index = count; count increments.
  - Entries beyond N_SPRITE_MAX are ignored.
  - `start`=1 on an edge moves to DRAW and drops `ready` the next cycle. If `sprite` and `start` are both high on the same edge, `start` wins and that entry is not stored.
- ROM mapping:
  - type[1]=0 selects SR0, type[1]=1 selects SR1.
  - Address = {type[0], row[3:0], col[3:0]}.
  - Word bit12 = transparent flag (1 = skip pixel); bits[11:0] = colour.
- game_mode (row r, column c of destination within sprite):
  - 0: ROM row=r, col=c.
  - 1: horizontal mirror, col=15-c.
  - 2: vertical mirror, row=15-r.
  - 3: both mirrors.
- State DRAW:
  - Sprites processed in load order, index 0 first; later sprites overwrite earlier ones.
  - Per sprite, scan r=0..15 outer, c=0..15 inner, one ROM read per cycle, pipelined.
  - The write for a pixel is issued the cycle after its ROM data is valid.
  - Destination is (X+c, Y+r) using 7-bit sums.
  - Write is suppressed (FB_CEN=1) if the pixel is transparent, or if X+c>63 or Y+r>63. Clipping applies; there is no wrap-around.
  - Throughput: 256 cycles per sprite plus pipeline drain of 2 cycles or fewer.
  - With count=0, go directly to DONE.
- State DONE:
  - `done`=1 and held until reset.
  - All CEN=1 and `FB_WEN`=1 permanently, so the host may drive the FB.
  - `start` and `sprite` are ignored.
- Unused ROM is kept at CEN=1.

Test Plan:
- Reset, then `start` with 0 sprites, `bg_color`=12'hB97 -> `ready` rises after 4096 clear cycles; `done` rises; all 4096 FB words = 12'hB97.
- One sprite type=0 at (0,0), mode 0, SR0 word 0 = 13'h0_ABC -> FB[0]=12'hABC; pixels with bit12=1 stay 12'hB97.
- Sprite type=3 at (60,60) -> only 4x4 region at x,y 60..63 written from SR1 addresses 256+; FB[0..] near origin unchanged (no wrap).
- Two opaque sprites overlapping at (10,10) and (14,10) -> overlap columns hold the second sprite's colours.
- Same sprite, game_mode=1 -> FB[(Y)*64+X] equals ROM col 15 of row 0; mode 3 -> equals ROM address {t0,4'hF,4'hF}.
- 21 sprite entries loaded -> only first 20 drawn; 21st region shows background; `sprite` and `start` on the same edge -> entry dropped, drawing starts.
